// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm path: state encodings, digit maxima and small helpers.
// Used by alarm_ring and the alarm-setting stage.
package alarm_pkg;

  typedef enum logic [2:0] {
    StDisarmed = 3'd0,
    StArmed    = 3'd1,
    StRinging  = 3'd2,
    StSnooze   = 3'd3
  } alarm_state_e;

  // Digit ranges shared with the alarm-setting stage.
  localparam int unsigned HOUR_MAX = 11;
  localparam int unsigned TMIN_MAX = 5;
  localparam int unsigned MIN_MAX  = 9;

  localparam int unsigned LedW = 16;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/flash_div.sv
// LED flash divider: toggles flash_o every HalfPeriod enabled cycles.
// A restart forces flash_o high and realigns the period.
module flash_div #(
  parameter int unsigned HalfPeriod = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic restart_i,
  output logic flash_o
);

  localparam int unsigned CntW = (HalfPeriod > 1) ? $clog2(HalfPeriod) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            flash_q, flash_d;

  always_comb begin
    cnt_d   = cnt_q;
    flash_d = flash_q;
    if (restart_i) begin
      cnt_d   = '0;
      flash_d = 1'b1;
    end else if (en_i) begin
      if (cnt_q == CntW'(HalfPeriod - 1)) begin
        cnt_d   = '0;
        flash_d = ~flash_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      flash_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      flash_q <= flash_d;
    end
  end

  assign flash_o = flash_q;

endmodule

// File: rtl/alarm_ring.sv
// Alarm ringer: rings on the rising edge of an alarm/current-time match, with snooze,
// dismiss and timeout. Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_ring import alarm_pkg::*; #(
  parameter int unsigned sys_freq   = 100000000,
  parameter int unsigned FLASH_HZ   = 2,
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  al_hour,
  input  logic [3:0]  al_t_min,
  input  logic [3:0]  al_min,
  input  logic [3:0]  cur_hour,
  input  logic [3:0]  cur_t_min,
  input  logic [3:0]  cur_min,
  input  logic        sec_tick,
  input  logic        alarm_en,
  input  logic        center,
  input  logic        left,
  output logic        ring,
  output logic [15:0] led,
  output logic [2:0]  state
);

  localparam int unsigned FlashHalf  = sys_freq / (2 * FLASH_HZ);
  localparam int unsigned SnoozeSecs = SNOOZE_MIN * 60;
  localparam int unsigned SecMax     = max_u(RING_SECS, SnoozeSecs);
  localparam int unsigned SecW       = $clog2(SecMax + 1);

  alarm_state_e    state_q, state_d;
  logic            match, match_q, match_d, trig;
  logic [SecW-1:0] sec_cnt_q, sec_cnt_d;
  logic            counting;
  logic            ring_expired;
  logic            flash, flash_restart;

  assign match   = (al_hour == cur_hour) && (al_t_min == cur_t_min) && (al_min == cur_min);
  assign match_d = match;
  // Only a fresh match fires, so arming inside a matching minute stays quiet.
  assign trig    = match & ~match_q;

  assign ring_expired = sec_tick && (sec_cnt_q == SecW'(RING_SECS - 1));

`ifdef ALARM_SNOOZE_EN
  logic snooze_expired;
  assign snooze_expired = sec_tick && (sec_cnt_q == SecW'(SnoozeSecs - 1));
  assign counting       = (state_q == StRinging) || (state_q == StSnooze);
`else
  assign counting       = (state_q == StRinging);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StDisarmed: begin
        if (alarm_en) state_d = StArmed;
      end
      StArmed: begin
        if (trig) state_d = StRinging;
      end
      StRinging: begin
        if (left) begin
          state_d = StArmed;
        end else if (center) begin
`ifdef ALARM_SNOOZE_EN
          state_d = StSnooze;
`else
          state_d = StArmed;
`endif
        end else if (ring_expired) begin
          state_d = StArmed;
        end
      end
`ifdef ALARM_SNOOZE_EN
      StSnooze: begin
        if (left) begin
          state_d = StArmed;
        end else if (snooze_expired) begin
          state_d = StRinging;
        end
      end
`endif
      default: state_d = StDisarmed;
    endcase
    if (!alarm_en) state_d = StDisarmed;
  end

  // Shared second counter: cleared on every state change, so it never wraps mid-state.
  always_comb begin
    sec_cnt_d = sec_cnt_q;
    if (state_d != state_q) begin
      sec_cnt_d = '0;
    end else if (counting && sec_tick) begin
      sec_cnt_d = sec_cnt_q + SecW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StDisarmed;
      match_q   <= 1'b0;
      sec_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      sec_cnt_q <= sec_cnt_d;
    end
  end

  assign flash_restart = (state_d == StRinging) && (state_q != StRinging);

  flash_div #(
    .HalfPeriod(FlashHalf)
  ) u_flash_div (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (state_q == StRinging),
    .restart_i(flash_restart),
    .flash_o  (flash)
  );

  assign ring  = (state_q == StRinging);
  assign led   = ring ? {LedW{flash}} : '0;
  assign state = state_q;

endmodule

// File: tb/tb_alarm_ring.sv
// Scoreboard bench for alarm_ring: stimulus queues expected outputs tagged by cycle,
// a negedge monitor pops and compares them. Honours ALARM_SNOOZE_EN.
module tb_alarm_ring;

  localparam int unsigned SysFreq   = 16;
  localparam int unsigned FlashHz   = 2;
  localparam int unsigned RingSecs  = 3;
  localparam int unsigned SnoozeMin = 1;

  localparam logic [2:0] SDis = 3'd0;
  localparam logic [2:0] SArm = 3'd1;
  localparam logic [2:0] SRng = 3'd2;
  localparam logic [2:0] SSnz = 3'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  al_hour, al_t_min, al_min;
  logic [3:0]  cur_hour, cur_t_min, cur_min;
  logic        sec_tick, alarm_en, center, left;
  logic        ring;
  logic [15:0] led;
  logic [2:0]  state;

  always #5 clk = ~clk;

  alarm_ring #(
    .sys_freq  (SysFreq),
    .FLASH_HZ  (FlashHz),
    .RING_SECS (RingSecs),
    .SNOOZE_MIN(SnoozeMin)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .al_hour  (al_hour),
    .al_t_min (al_t_min),
    .al_min   (al_min),
    .cur_hour (cur_hour),
    .cur_t_min(cur_t_min),
    .cur_min  (cur_min),
    .sec_tick (sec_tick),
    .alarm_en (alarm_en),
    .center   (center),
    .left     (left),
    .ring     (ring),
    .led      (led),
    .state    (state)
  );

  typedef struct {
    int unsigned at;
    string       name;
    logic [2:0]  st;
    logic        rg;
    logic [15:0] ld;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int unsigned ring_start = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.at < cyc) begin
        failures++;
        $display("FAIL %s: sample for cycle %0d missed (now %0d)", mon_e.name, mon_e.at, cyc);
      end else if (state !== mon_e.st || ring !== mon_e.rg || led !== mon_e.ld) begin
        failures++;
        $display("FAIL %s @%0d: got state=%0d ring=%0b led=%h, expected state=%0d ring=%0b led=%h",
                 mon_e.name, cyc, state, ring, led, mon_e.st, mon_e.rg, mon_e.ld);
      end
    end
  end

  task automatic expect_at(input int unsigned at, input string name, input logic [2:0] st,
                           input logic rg, input logic [15:0] ld);
    exp_t e;
    int   i;
    e.at = at; e.name = name; e.st = st; e.rg = rg; e.ld = ld;
    i = 0;
    while (i < sb.size() && sb[i].at <= at) i++;
    sb.insert(i, e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
  endtask

  function automatic logic [15:0] flash_led(input int unsigned c);
    return ((((c - ring_start) / 4) % 2) == 0) ? 16'hFFFF : 16'h0000;
  endfunction

  // From ARMED with cur=7:3:5: move the alarm away and back so it newly matches.
  task automatic retrigger(input string name);
    al_min = 4'd4;
    step();
    step();
    al_min = 4'd5;
    expect_at(cyc + 1, name, SRng, 1'b1, 16'hFFFF);
    ring_start = cyc + 1;
    step();
  endtask

  initial begin
    rst = 1'b1; alarm_en = 1'b0; center = 1'b0; left = 1'b0; sec_tick = 1'b0;
    al_hour = 4'd0; al_t_min = 4'd0; al_min = 4'd0;
    cur_hour = 4'd0; cur_t_min = 4'd0; cur_min = 4'd0;
    step();
    step();
    expect_at(cyc + 1, "reset", SDis, 1'b0, 16'h0000);
    step();
    rst = 1'b0;

    // Arm with alarm 7:3:5, time 7:3:4.
    al_hour = 4'd7; al_t_min = 4'd3; al_min = 4'd5;
    cur_hour = 4'd7; cur_t_min = 4'd3; cur_min = 4'd4;
    alarm_en = 1'b1;
    expect_at(cyc + 1, "arm", SArm, 1'b0, 16'h0000);
    step(); step(); step();

    // Trigger and flash pattern.
    cur_min = 4'd5;
    expect_at(cyc + 1, "trig_ring", SRng, 1'b1, 16'hFFFF);
    ring_start = cyc + 1;
    expect_at(cyc + 4, "flash_hi_end", SRng, 1'b1, 16'hFFFF);
    expect_at(cyc + 5, "flash_lo", SRng, 1'b1, 16'h0000);
    expect_at(cyc + 8, "flash_lo_end", SRng, 1'b1, 16'h0000);
    expect_at(cyc + 9, "flash_hi2", SRng, 1'b1, 16'hFFFF);
    repeat (10) step();

    // Timeout after three ticks.
    pulse_tick(); step();
    pulse_tick(); step();
    expect_at(cyc, "pre_timeout", SRng, 1'b1, flash_led(cyc));
    sec_tick = 1'b1;
    expect_at(cyc + 1, "timeout", SArm, 1'b0, 16'h0000);
    step();
    sec_tick = 1'b0;
    expect_at(cyc + 3, "no_retrig", SArm, 1'b0, 16'h0000);
    repeat (4) step();

    // Snooze: two ticks, then center with a would-be-expiry tick in the same cycle.
    retrigger("retrig_snooze");
    pulse_tick();
    pulse_tick();
    center = 1'b1; sec_tick = 1'b1;
`ifdef ALARM_SNOOZE_EN
    expect_at(cyc + 1, "snooze_enter", SSnz, 1'b0, 16'h0000);
`else
    expect_at(cyc + 1, "center_dismiss", SArm, 1'b0, 16'h0000);
`endif
    step();
    center = 1'b0; sec_tick = 1'b0;
`ifdef ALARM_SNOOZE_EN
    for (int i = 0; i < 59; i++) pulse_tick();
    expect_at(cyc, "snooze_hold", SSnz, 1'b0, 16'h0000);
    sec_tick = 1'b1;
    expect_at(cyc + 1, "snooze_expire", SRng, 1'b1, 16'hFFFF);
    ring_start = cyc + 1;
    step();
    sec_tick = 1'b0;
    expect_at(cyc + 4, "resnooze_flash", SRng, 1'b1, flash_led(cyc + 4));
    repeat (5) step();
`else
    retrigger("retrig_nosnooze");
`endif

    // Priority: left and center together (plus a tick) dismiss.
    center = 1'b1; left = 1'b1; sec_tick = 1'b1;
    expect_at(cyc + 1, "left_center", SArm, 1'b0, 16'h0000);
    step();
    center = 1'b0; left = 1'b0; sec_tick = 1'b0;
    step(); step();

    // Priority: alarm_en low beats left.
    retrigger("retrig_disable");
    alarm_en = 1'b0; left = 1'b1;
    expect_at(cyc + 1, "en_low_left", SDis, 1'b0, 16'h0000);
    step();
    left = 1'b0;
    step();

    // No false trigger when arming inside a matching minute.
    alarm_en = 1'b1;
    expect_at(cyc + 1, "arm_matching", SArm, 1'b0, 16'h0000);
    expect_at(cyc + 6, "arm_matching_6", SArm, 1'b0, 16'h0000);
    expect_at(cyc + 20, "arm_matching_20", SArm, 1'b0, 16'h0000);
    repeat (21) step();

    // Reset mid-ring.
    retrigger("retrig_rst");
    step();
    rst = 1'b1;
    expect_at(cyc + 1, "rst_midring", SDis, 1'b0, 16'h0000);
    step();
    rst = 1'b0;
    expect_at(cyc + 1, "rearm_after_rst", SArm, 1'b0, 16'h0000);
    expect_at(cyc + 4, "no_trig_after_rst", SArm, 1'b0, 16'h0000);
    repeat (5) step();

    for (int i = 0; i < 50 && sb.size() > 0; i++) step();
    @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations never sampled, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
